// File: rtl/piso_pkg.sv
// Shared types and sizing for the parallel-in serial-out serializer.
// State encoding, default frame width and the bit-counter width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/piso_serializer.sv
// Purpose: serialize a WIDTH-bit word LSB first with a frame enable; PIPO_PARITY_EN appends an even-parity bit.
// Latency: bit 0 on ser_out one cycle after the handshake; done WIDTH+1 cycles after it (WIDTH+2 with parity).
// Backpressure: in_ready is low for the whole frame; words offered while busy are ignored.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
`ifdef PIPO_PARITY_EN
    logic               par_q;
`endif

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            ser_out  <= 1'b0;
            ser_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
`ifdef PIPO_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // Bit 0 goes straight to ser_out so it appears the cycle after the handshake.
                        state    <= ST_SHIFT;
                        shreg    <= in_data >> 1;
                        cnt      <= '0;
                        ser_out  <= in_data[0];
                        ser_en   <= 1'b1;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
`ifdef PIPO_PARITY_EN
                        par_q    <= ^in_data;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
`ifdef PIPO_PARITY_EN
                        state    <= ST_PAR;
                        ser_out  <= par_q;
`else
                        state    <= ST_IDLE;
                        ser_out  <= 1'b0;
                        ser_en   <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
`endif
                    end else begin
                        ser_out <= shreg[0];
                        shreg   <= shreg >> 1;
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
`ifdef PIPO_PARITY_EN
                ST_PAR: begin
                    state    <= ST_IDLE;
                    ser_out  <= 1'b0;
                    ser_en   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: scoreboard of expected serial bits and frame words,
// with a behavioural model of the downstream serial-in parallel-out register.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PIPO_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ser_out;
    logic         ser_en;
    logic         busy;
    logic         done;

    piso_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_en   (ser_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int run = 0;

    logic          bitq[$];
    logic [FB-1:0] wordq[$];
    int            hsq[$];
    logic [FB-1:0] sipo;
    logic          exp_b;
    logic [FB-1:0] exp_w;
    int            exp_c;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream register: shifts in at its MSB while loaded, clears when the enable drops.
    always @(posedge clk or posedge rst) begin
        if (rst)         sipo <= '0;
        else if (ser_en) sipo <= {ser_out, sipo[FB-1:1]};
        else             sipo <= '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            bitq.delete();
            wordq.delete();
            hsq.delete();
            run = 0;
        end else begin
            checks++;
            if (busy !== ser_en) begin
                errors++;
                $display("FAIL busy_vs_en cyc=%0d busy=%b ser_en=%b (must match)", cyc, busy, ser_en);
            end
            if (ser_en === 1'b1) begin
                run++;
                checks++;
                if (bitq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit cyc=%0d ser_en=1 with no bit expected", cyc);
                end else begin
                    exp_b = bitq.pop_front();
                    if (ser_out !== exp_b) begin
                        errors++;
                        $display("FAIL ser_out cyc=%0d got=%b exp=%b", cyc, ser_out, exp_b);
                    end
                end
            end else if (run > 0) begin
                checks++;
                if (run != FB) begin
                    errors++;
                    $display("FAIL frame_len cyc=%0d got=%0d exp=%0d", cyc, run, FB);
                end
                run = 0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (wordq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done cyc=%0d", cyc);
                end else begin
                    exp_w = wordq.pop_front();
                    exp_c = hsq.pop_front() + FB + 1;
                    checks++;
                    if (sipo !== exp_w) begin
                        errors++;
                        $display("FAIL downstream_word cyc=%0d got=%h exp=%h", cyc, sipo, exp_w);
                    end
                    checks++;
                    if (cyc != exp_c) begin
                        errors++;
                        $display("FAIL done_latency got_cyc=%0d exp_cyc=%0d", cyc, exp_c);
                    end
                    checks++;
                    if (ser_en !== 1'b0 || in_ready !== 1'b1 || bitq.size() != 0) begin
                        errors++;
                        $display("FAIL done_cycle_state ser_en=%b in_ready=%b pending_bits=%0d exp 0/1/0",
                                 ser_en, in_ready, bitq.size());
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                for (int i = 0; i < W; i++) bitq.push_back(in_data[i]);
`ifdef PIPO_PARITY_EN
                bitq.push_back(^in_data);
                wordq.push_back({^in_data, in_data});
`else
                wordq.push_back(in_data);
`endif
                hsq.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] d, output int hc, output bit ok);
        ok = 1'b0;
        hc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                hc = cyc;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            in_data = W'($urandom);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ser_out, ser_en, busy, done, in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00000", {ser_out, ser_en, busy, done, in_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got=%b exp=0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single();
        int hc;
        bit ok;
        bit seen;
        send(4'b1011, hc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_accept no handshake within budget");
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL single_done no done within budget");
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ser_en !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width done=%b ser_en=%b exp 0/0", done, ser_en);
        end
    endtask

    task automatic test_back_to_back();
        int h1 = 0;
        int h2 = 0;
        bit got1 = 1'b0;
        bit got2 = 1'b0;
        bit seen;
        in_valid = 1'b1;
        in_data  = 4'h5;
        for (int i = 0; i < 40 && !got1; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got1 = 1'b1;
                h1 = cyc;
            end
        end
        @(posedge clk);
        #1;
        in_data = 4'hA;
        for (int i = 0; i < 40 && !got2; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got2 = 1'b1;
                h2 = cyc;
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_done_cycle done=%b exp=1", done);
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (!got1 || !got2 || (h2 - h1) != FB + 1) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d exp=%0d (accepted %b/%b)", h2 - h1, FB + 1, got1, got2);
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_done second frame never completed");
        end
    endtask

    task automatic test_ignore_busy();
        int hc;
        int n = 0;
        bit ok;
        bit rdy = 1'b0;
        bit seen;
        send(4'h3, hc, ok);
        in_valid = 1'b1;
        in_data  = 4'hF;
        for (int i = 0; i < 40 && !rdy; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) rdy = 1'b1;
            else n++;
        end
        checks++;
        if (!ok || !rdy || n != FB || done !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore not_ready_cycles=%0d exp=%0d done=%b exp=1", n, FB, done);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy_ignore_done 4'hF frame never completed");
        end
    endtask

    task automatic test_reset_midframe();
        int hc;
        int d0;
        bit ok;
        bit seen;
        send(4'h9, hc, ok);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_out, ser_en, busy, done, in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL midframe_reset got=%b exp=00000", {ser_out, ser_en, busy, done, in_ready});
        end
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (FB + 3) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abandoned_done got=%0d pulses exp=0", done_cnt - d0);
        end
        send(4'h6, hc, ok);
        wait_done(seen);
        checks++;
        if (!ok || !seen) begin
            errors++;
            $display("FAIL after_reset_frame accept=%b done=%b exp 1/1", ok, seen);
        end
    endtask

`ifdef PIPO_PARITY_EN
    task automatic test_parity();
        int hc;
        bit ok;
        bit seen;
        send(4'b1011, hc, ok);
        wait_done(seen);
        checks++;
        if (!ok || !seen) begin
            errors++;
            $display("FAIL parity_odd_word accept=%b done=%b exp 1/1", ok, seen);
        end
        send(4'b0011, hc, ok);
        wait_done(seen);
        checks++;
        if (!ok || !seen) begin
            errors++;
            $display("FAIL parity_even_word accept=%b done=%b exp 1/1", ok, seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
`ifdef PIPO_PARITY_EN
        test_parity();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (wordq.size() != 0 || bitq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect words=%0d bits=%0d exp 0/0", wordq.size(), bitq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
